// File: rtl/fxu_pkg.sv
// Shared definitions for the fixed-point unit reservation station.
package fxu_pkg;

  localparam int FXU_TAG_W  = 4;
  localparam int FXU_DATA_W = 16;
  localparam int OP_W       = 4;
  localparam int IMM_W      = 8;

  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OP_W-1:0] OP_MOV  = 4'h4;
  localparam logic [OP_W-1:0] OP_MOVL = 4'h5;
  localparam logic [OP_W-1:0] OP_MOVH = 4'h6;

  typedef struct packed {
    logic                  rdy;
    logic [FXU_TAG_W-1:0]  tag;
    logic [FXU_DATA_W-1:0] val;
  } rs_src_t;

  typedef struct packed {
    logic                 valid;
    logic [OP_W-1:0]      opcode;
    logic [FXU_TAG_W-1:0] rob;
    logic [IMM_W-1:0]     imm;
    rs_src_t              a;
    rs_src_t              b;
  } rs_entry_t;

endpackage

// File: rtl/fxu_rs_entry.sv
// One reservation-station slot: dispatch write, CDB wakeup, ready flag.
module rs_entry
  import fxu_pkg::*;
#(
  parameter int TAG_W  = FXU_TAG_W,
  parameter int DATA_W = FXU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              wr_i,
  input  logic              clr_i,
  input  logic [OP_W-1:0]   opcode_i,
  input  logic [TAG_W-1:0]  rob_i,
  input  logic [IMM_W-1:0]  imm_i,
  input  logic              a_rdy_i,
  input  logic [TAG_W-1:0]  a_tag_i,
  input  logic [DATA_W-1:0] a_val_i,
  input  logic              b_rdy_i,
  input  logic [TAG_W-1:0]  b_tag_i,
  input  logic [DATA_W-1:0] b_val_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_value_i,
  output logic              valid_o,
  output logic              ready_o,
  output logic [OP_W-1:0]   opcode_o,
  output logic [TAG_W-1:0]  rob_o,
  output logic [IMM_W-1:0]  imm_o,
  output logic [DATA_W-1:0] va_o,
  output logic [DATA_W-1:0] vb_o
);

  logic              vld_q;
  logic [OP_W-1:0]   op_q;
  logic [TAG_W-1:0]  rob_q;
  logic [IMM_W-1:0]  imm_q;
  logic              a_rdy_q, b_rdy_q;
  logic [TAG_W-1:0]  a_tag_q, b_tag_q;
  logic [DATA_W-1:0] a_val_q, b_val_q;

  logic a_hit, b_hit, a_dhit, b_dhit;

  assign a_hit  = cdb_valid_i && vld_q && !a_rdy_q &&
                  (a_tag_q == cdb_tag_i);
  assign b_hit  = cdb_valid_i && vld_q && !b_rdy_q &&
                  (b_tag_q == cdb_tag_i);
  // same-cycle broadcast of a source still in flight at dispatch
  assign a_dhit = cdb_valid_i && !a_rdy_i &&
                  (a_tag_i == cdb_tag_i);
  assign b_dhit = cdb_valid_i && !b_rdy_i &&
                  (b_tag_i == cdb_tag_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      op_q    <= '0;
      rob_q   <= '0;
      imm_q   <= '0;
      a_rdy_q <= 1'b0;
      a_tag_q <= '0;
      a_val_q <= '0;
      b_rdy_q <= 1'b0;
      b_tag_q <= '0;
      b_val_q <= '0;
    end else if (flush_i) begin
      vld_q <= 1'b0;
    end else if (wr_i) begin
      vld_q   <= 1'b1;
      op_q    <= opcode_i;
      rob_q   <= rob_i;
      imm_q   <= imm_i;
      a_rdy_q <= a_rdy_i | a_dhit;
      a_tag_q <= a_tag_i;
      a_val_q <= a_rdy_i ? a_val_i : cdb_value_i;
      b_rdy_q <= b_rdy_i | b_dhit;
      b_tag_q <= b_tag_i;
      b_val_q <= b_rdy_i ? b_val_i : cdb_value_i;
    end else begin
      if (clr_i) vld_q <= 1'b0;
      if (a_hit) begin
        a_rdy_q <= 1'b1;
        a_val_q <= cdb_value_i;
      end
      if (b_hit) begin
        b_rdy_q <= 1'b1;
        b_val_q <= cdb_value_i;
      end
    end
  end

  assign valid_o  = vld_q;
  assign ready_o  = vld_q & a_rdy_q & b_rdy_q;
  assign opcode_o = op_q;
  assign rob_o    = rob_q;
  assign imm_o    = imm_q;
  assign va_o     = a_val_q;
  assign vb_o     = b_val_q;

endmodule

// File: rtl/fxu_rs.sv
// FXU reservation station: DEPTH slots, lowest-free dispatch,
// lowest-ready select, issue at most every other cycle.
module fxu_rs
  import fxu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = FXU_TAG_W,
  parameter int DATA_W = FXU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [OP_W-1:0]   disp_opcode,
  input  logic [TAG_W-1:0]  disp_rob,
  input  logic              disp_a_rdy,
  input  logic              disp_b_rdy,
  input  logic [TAG_W-1:0]  disp_a_tag,
  input  logic [TAG_W-1:0]  disp_b_tag,
  input  logic [DATA_W-1:0] disp_a_val,
  input  logic [DATA_W-1:0] disp_b_val,
  input  logic [IMM_W-1:0]  disp_imm,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              iss_valid,
  output logic [OP_W-1:0]   iss_opcode,
  output logic [TAG_W-1:0]  iss_rob,
  output logic [DATA_W-1:0] iss_va,
  output logic [DATA_W-1:0] iss_vb,
  output logic [IMM_W-1:0]  iss_imm
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  vld, rdy, wr, clr;
  logic [OP_W-1:0]   e_op  [DEPTH];
  logic [TAG_W-1:0]  e_rob [DEPTH];
  logic [IMM_W-1:0]  e_imm [DEPTH];
  logic [DATA_W-1:0] e_va  [DEPTH];
  logic [DATA_W-1:0] e_vb  [DEPTH];

  logic             free_found, sel_found;
  logic [IDX_W-1:0] free_idx, sel_idx;
  logic             disp_fire, sel_ok;

  logic              iss_valid_q;
  logic [OP_W-1:0]   iss_op_q;
  logic [TAG_W-1:0]  iss_rob_q;
  logic [DATA_W-1:0] iss_va_q, iss_vb_q;
  logic [IMM_W-1:0]  iss_imm_q;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!vld[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (rdy[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign disp_ready = free_found;
  assign disp_fire  = disp_valid && free_found && !flush;
  // iss_valid_q doubles as the spacing flag: FXU reads data a cycle late
  assign sel_ok     = sel_found && !iss_valid_q && !flush;

  always_comb begin
    wr  = '0;
    clr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr[i]  = disp_fire && (free_idx == IDX_W'(i));
      clr[i] = sel_ok && (sel_idx == IDX_W'(i));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rs_entry #(
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
    ) u_ent (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .wr_i        (wr[g]),
      .clr_i       (clr[g]),
      .opcode_i    (disp_opcode),
      .rob_i       (disp_rob),
      .imm_i       (disp_imm),
      .a_rdy_i     (disp_a_rdy),
      .a_tag_i     (disp_a_tag),
      .a_val_i     (disp_a_val),
      .b_rdy_i     (disp_b_rdy),
      .b_tag_i     (disp_b_tag),
      .b_val_i     (disp_b_val),
      .cdb_valid_i (cdb_valid),
      .cdb_tag_i   (cdb_tag),
      .cdb_value_i (cdb_value),
      .valid_o     (vld[g]),
      .ready_o     (rdy[g]),
      .opcode_o    (e_op[g]),
      .rob_o       (e_rob[g]),
      .imm_o       (e_imm[g]),
      .va_o        (e_va[g]),
      .vb_o        (e_vb[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_rob_q   <= '0;
      iss_va_q    <= '0;
      iss_vb_q    <= '0;
      iss_imm_q   <= '0;
    end else begin
      iss_valid_q <= sel_ok;
      if (sel_ok) begin
        iss_op_q  <= e_op[sel_idx];
        iss_rob_q <= e_rob[sel_idx];
        iss_va_q  <= e_va[sel_idx];
        iss_vb_q  <= e_vb[sel_idx];
        iss_imm_q <= e_imm[sel_idx];
      end
    end
  end

  assign iss_valid  = iss_valid_q;
  assign iss_opcode = iss_op_q;
  assign iss_rob    = iss_rob_q;
  assign iss_va     = iss_va_q;
  assign iss_vb     = iss_vb_q;
  assign iss_imm    = iss_imm_q;

endmodule

// File: tb/tb_fxu_rs.sv
// Directed bench for fxu_rs: dispatch, wakeup, bypass, full,
// spacing, flush and async reset.
module tb_fxu_rs;
  import fxu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        disp_valid = 1'b0;
  logic        disp_ready;
  logic [3:0]  disp_opcode = '0;
  logic [3:0]  disp_rob = '0;
  logic        disp_a_rdy = 1'b0;
  logic        disp_b_rdy = 1'b0;
  logic [3:0]  disp_a_tag = '0;
  logic [3:0]  disp_b_tag = '0;
  logic [15:0] disp_a_val = '0;
  logic [15:0] disp_b_val = '0;
  logic [7:0]  disp_imm = '0;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_tag = '0;
  logic [15:0] cdb_value = '0;
  logic        iss_valid;
  logic [3:0]  iss_opcode;
  logic [3:0]  iss_rob;
  logic [15:0] iss_va, iss_vb;
  logic [7:0]  iss_imm;

  int n_chk = 0;
  int n_err = 0;

  fxu_rs dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .disp_valid  (disp_valid),
    .disp_ready  (disp_ready),
    .disp_opcode (disp_opcode),
    .disp_rob    (disp_rob),
    .disp_a_rdy  (disp_a_rdy),
    .disp_b_rdy  (disp_b_rdy),
    .disp_a_tag  (disp_a_tag),
    .disp_b_tag  (disp_b_tag),
    .disp_a_val  (disp_a_val),
    .disp_b_val  (disp_b_val),
    .disp_imm    (disp_imm),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_value   (cdb_value),
    .iss_valid   (iss_valid),
    .iss_opcode  (iss_opcode),
    .iss_rob     (iss_rob),
    .iss_va      (iss_va),
    .iss_vb      (iss_vb),
    .iss_imm     (iss_imm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [3:0] op, input logic [3:0] rob,
                      input logic ar, input logic [3:0] at,
                      input logic [15:0] av,
                      input logic br, input logic [3:0] bt,
                      input logic [15:0] bv, input logic [7:0] imm);
    disp_valid  = 1'b1;
    disp_opcode = op;
    disp_rob    = rob;
    disp_a_rdy  = ar;
    disp_a_tag  = at;
    disp_a_val  = av;
    disp_b_rdy  = br;
    disp_b_tag  = bt;
    disp_b_val  = bv;
    disp_imm    = imm;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [15:0] v);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_value = v;
  endtask

  initial begin
    #12;
    chk("rst_iss_valid", 32'(iss_valid), 32'd0);
    chk("rst_disp_ready", 32'(disp_ready), 32'd1);
    chk("rst_iss_rob", 32'(iss_rob), 32'd0);
    chk("rst_iss_va", 32'(iss_va), 32'd0);
    rst_n = 1'b1;
    tick();

    // both ready: issue one edge after dispatch
    disp(OP_ADD, 4'd3, 1'b1, 4'd0, 16'd5, 1'b1, 4'd0, 16'd7, 8'h3C);
    tick();
    disp_valid = 1'b0;
    chk("add_no_early", 32'(iss_valid), 32'd0);
    tick();
    chk("add_valid", 32'(iss_valid), 32'd1);
    chk("add_rob", 32'(iss_rob), 32'd3);
    chk("add_op", 32'(iss_opcode), 32'(OP_ADD));
    chk("add_va", 32'(iss_va), 32'd5);
    chk("add_vb", 32'(iss_vb), 32'd7);
    chk("add_imm", 32'(iss_imm), 32'h3C);
    tick();
    chk("add_gap", 32'(iss_valid), 32'd0);
    chk("add_hold_va", 32'(iss_va), 32'd5);
    chk("add_hold_vb", 32'(iss_vb), 32'd7);

    // wakeup through the CDB
    disp(OP_SUB, 4'd2, 1'b1, 4'd0, 16'd10, 1'b0, 4'd6, 16'd0, 8'h01);
    tick();
    disp_valid = 1'b0;
    tick();
    chk("sub_wait", 32'(iss_valid), 32'd0);
    cdb(4'd6, 16'd4);
    tick();
    cdb_valid = 1'b0;
    chk("sub_wait2", 32'(iss_valid), 32'd0);
    tick();
    chk("sub_valid", 32'(iss_valid), 32'd1);
    chk("sub_rob", 32'(iss_rob), 32'd2);
    chk("sub_op", 32'(iss_opcode), 32'(OP_SUB));
    chk("sub_va", 32'(iss_va), 32'd10);
    chk("sub_vb", 32'(iss_vb), 32'd4);
    tick();

    // dispatch-time bypass from the CDB
    disp(OP_ADD, 4'd5, 1'b1, 4'd0, 16'h0011, 1'b0, 4'd9, 16'h0, 8'h00);
    cdb(4'd9, 16'h1234);
    tick();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    tick();
    chk("byp_valid", 32'(iss_valid), 32'd1);
    chk("byp_rob", 32'(iss_rob), 32'd5);
    chk("byp_vb", 32'(iss_vb), 32'h1234);
    tick();

    // fill all four slots with ops waiting on b
    disp(OP_ADD, 4'd4, 1'b1, 4'd0, 16'h0A, 1'b0, 4'd10, 16'h0, 8'h0);
    tick();
    disp(OP_SUB, 4'd5, 1'b1, 4'd0, 16'h0B, 1'b0, 4'd11, 16'h0, 8'h0);
    tick();
    disp(OP_ADD, 4'd6, 1'b1, 4'd0, 16'h0C, 1'b0, 4'd12, 16'h0, 8'h0);
    tick();
    chk("fill3_ready", 32'(disp_ready), 32'd1);
    disp(OP_SUB, 4'd7, 1'b1, 4'd0, 16'h0D, 1'b0, 4'd11, 16'h0, 8'h0);
    tick();
    chk("full_ready", 32'(disp_ready), 32'd0);
    disp(OP_MOV, 4'd8, 1'b1, 4'd0, 16'hEE, 1'b1, 4'd0, 16'h0, 8'h0);
    tick();
    disp_valid = 1'b0;
    chk("full_drop", 32'(iss_valid), 32'd0);
    chk("full_ready2", 32'(disp_ready), 32'd0);
    tick();
    chk("full_drop2", 32'(iss_valid), 32'd0);
    cdb(4'd11, 16'h00AA);
    tick();
    cdb_valid = 1'b0;
    tick();
    chk("wake1_valid", 32'(iss_valid), 32'd1);
    chk("wake1_rob", 32'(iss_rob), 32'd5);
    chk("wake1_va", 32'(iss_va), 32'h0B);
    chk("wake1_vb", 32'(iss_vb), 32'hAA);
    chk("wake1_ready", 32'(disp_ready), 32'd1);
    tick();
    chk("wake_gap", 32'(iss_valid), 32'd0);
    tick();
    chk("wake3_valid", 32'(iss_valid), 32'd1);
    chk("wake3_rob", 32'(iss_rob), 32'd7);
    chk("wake3_vb", 32'(iss_vb), 32'hAA);
    tick();

    // two ready ops back to back: one idle cycle between issues
    disp(OP_MOVL, 4'd9, 1'b1, 4'd0, 16'd1, 1'b1, 4'd0, 16'd2, 8'h11);
    tick();
    disp(OP_MOVH, 4'd10, 1'b1, 4'd0, 16'd3, 1'b1, 4'd0, 16'd4, 8'h22);
    tick();
    disp_valid = 1'b0;
    chk("pair1_valid", 32'(iss_valid), 32'd1);
    chk("pair1_rob", 32'(iss_rob), 32'd9);
    tick();
    chk("pair_gap", 32'(iss_valid), 32'd0);
    chk("pair_hold", 32'(iss_rob), 32'd9);
    tick();
    chk("pair2_valid", 32'(iss_valid), 32'd1);
    chk("pair2_rob", 32'(iss_rob), 32'd10);
    chk("pair2_op", 32'(iss_opcode), 32'(OP_MOVH));
    chk("pair2_imm", 32'(iss_imm), 32'h22);
    tick();

    // flush with two pending ops, a ready dispatch and a CDB hit
    disp(OP_ADD, 4'd11, 1'b1, 4'd0, 16'd1, 1'b1, 4'd0, 16'd1, 8'h0);
    cdb(4'd10, 16'h5555);
    flush = 1'b1;
    tick();
    flush      = 1'b0;
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    chk("flush_iss", 32'(iss_valid), 32'd0);
    chk("flush_ready", 32'(disp_ready), 32'd1);
    tick();
    chk("flush_iss2", 32'(iss_valid), 32'd0);
    cdb(4'd12, 16'h6666);
    tick();
    cdb_valid = 1'b0;
    tick();
    chk("flush_iss3", 32'(iss_valid), 32'd0);

    // async reset with three valid entries
    disp(OP_ADD, 4'd12, 1'b0, 4'd13, 16'h0, 1'b1, 4'd0, 16'h1, 8'h0);
    tick();
    disp(OP_ADD, 4'd13, 1'b0, 4'd13, 16'h0, 1'b1, 4'd0, 16'h2, 8'h0);
    tick();
    disp(OP_ADD, 4'd14, 1'b0, 4'd13, 16'h0, 1'b1, 4'd0, 16'h3, 8'h0);
    tick();
    disp_valid = 1'b0;
    cdb(4'd13, 16'h7777);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_iss", 32'(iss_valid), 32'd0);
    chk("arst_rob", 32'(iss_rob), 32'd0);
    chk("arst_va", 32'(iss_va), 32'd0);
    chk("arst_vb", 32'(iss_vb), 32'd0);
    chk("arst_imm", 32'(iss_imm), 32'd0);
    chk("arst_op", 32'(iss_opcode), 32'd0);
    chk("arst_ready", 32'(disp_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    cdb_valid = 1'b0;
    tick();
    chk("arst_no_issue", 32'(iss_valid), 32'd0);
    chk("arst_ready2", 32'(disp_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fxu_rs.md
# fxu_rs

Reservation station for the fixed-point unit: holds dispatched integer ops (ADD/SUB/MOV/MOVL/MOVH) until both source operands are available, capturing missing operands from the common data bus (CDB), then issues one ready op at a time to the FXU. Sits between the dispatch/rename stage (upstream) and the FXU (downstream); the FXU's result returns to the ROB and CDB.

## Interface
- DEPTH, 4, number of entries (2..8)
- TAG_W, 4, ROB index / operand tag width
- DATA_W, 16, operand width

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all entries (mispredict)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  at least one free entry
- disp_opcode  in  4  op code
- disp_rob  in  TAG_W  ROB index of the op
- disp_a_rdy / disp_b_rdy  in  1  source value already present
- disp_a_tag / disp_b_tag  in  TAG_W  producing ROB index when not ready
- disp_a_val / disp_b_val  in  DATA_W  source value when ready
- disp_imm  in  8  immediate
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_W  ROB index of result
- cdb_value  in  DATA_W  result value
- iss_valid  out  1  op issued to FXU this cycle
- iss_opcode  out  4; iss_rob  out  TAG_W; iss_va / iss_vb  out  DATA_W; iss_imm  out  8  issued op fields

## Operation
- Per entry: valid, opcode, rob, imm, and for each source: rdy, tag, val.
- Dispatch: when disp_valid && disp_ready, op written to lowest-numbered free entry. Dispatch with disp_valid && !disp_ready is ignored (upstream must hold).
- Dispatch bypass: if cdb_valid and cdb_tag equals a not-ready dispatching source tag in the same cycle, the entry is written with that source ready and val = cdb_value.
- Wakeup: every valid entry with a not-ready source whose tag equals cdb_tag (cdb_valid=1) captures cdb_value and sets rdy. Both sources may wake on the same broadcast.
- Select: eligible = valid && a.rdy && b.rdy (registered bits only). Lowest-numbered eligible entry is chosen; its fields load the iss_* registers and the entry is freed.
- Issue spacing: the FXU registers valid one cycle after issue but reads data combinationally, so iss_* data hold their value from the issue cycle through the following cycle. iss_valid is never high two consecutive cycles; select is suppressed the cycle after an issue.
- MOV/MOVL/MOVH ops arrive with b marked ready (value don't-care); the station does not decode opcodes.
- Flush: all valid bits cleared at the edge; a dispatch in the same cycle is dropped; iss_valid low next cycle. CDB ignored that cycle.
- Width rule: values are stored and forwarded unmodified; no arithmetic in this block.

## Timing
- Reset: all entries invalid, disp_ready=1, iss_valid=0, iss_opcode/iss_rob/iss_va/iss_vb/iss_imm=0, issue-spacing flag clear.
- All outputs registered except disp_ready (combinational from registered valid bits; an entry freed by issue this cycle is not counted until next cycle).
- Minimum latency dispatch-with-both-ready -> iss_valid: 1 cycle.
- CDB wakeup at edge N -> earliest iss_valid at edge N+1.
- Full: DEPTH valid entries -> disp_ready=0; a simultaneous issue frees one entry, disp_ready=1 the next cycle.
- Same-cycle dispatch and issue never touch the same entry (dispatch targets free entries only).
- Reset asserted mid-operation clears everything immediately; no partial issue observable.

## Structure
- Shared package fxu_pkg: opcode constants (ADD=4'h0, SUB=4'h1, MOV=4'h4, MOVL=4'h5, MOVH=4'h6), TAG_W/DATA_W defaults, entry struct type.
- One sub-module natural: rs_entry (single entry storage with dispatch write, CDB wakeup compare, and ready output), instantiated DEPTH times; select and free-slot find are priority encoders in the top.

## Test plan
- Dispatch ADD rob=3, a=5, b=7 both ready -> iss_valid next cycle with iss_rob=3, va=5, vb=7; data held one extra cycle; iss_valid low that cycle.
- Dispatch SUB rob=2, a ready=10, b tag=6 -> no issue; CDB tag=6 value=4 -> iss_valid one cycle later with va=10, vb=4.
- Dispatch with b tag=9 while cdb_tag=9 value=0x1234 same cycle -> entry issues next cycle with vb=0x1234.
- Fill 4 entries with unready ops -> disp_ready=0, further dispatch ignored; one CDB wakes entries 1 and 3 -> entry 1 issues first, entry 3 two cycles later; disp_ready returns to 1 after first issue.
- Two ready entries -> issues separated by exactly one idle cycle; flush with pending ops and concurrent dispatch -> no further iss_valid, disp_ready=1.
- rst_n low mid-run with 3 valid entries -> immediately iss_valid=0, all outputs 0, disp_ready=1.
